ud_sweep_ctrl: RTL and testbench

//  Sequencer for the up/down counter datapath: on start, loads a low limit, counts up to a

---
 rtl/ud_sweep_ctrl_pkg.sv | 16 +
 rtl/ud_counter_core.sv | 24 ++
 rtl/ud_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_ud_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ud_sweep_ctrl_pkg.sv
// Shared definitions for the up/down sweep sequencer: FSM state encoding and
// counter direction constants.
package ud_sweep_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_UP    = 3'd1,
      ST_DWELL = 3'd2,
      ST_DOWN  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/ud_counter_core.sv
// WIDTH-bit up/down counter register: load has priority over a count step.
module ud_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_down,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= up_down ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/ud_sweep_ctrl.sv
// Sweep sequencer: load lo, count up to hi, optionally dwell, count down to lo, pulse done.
// Optional dwell at the ceiling is built when SWEEP_DWELL_EN is defined.
module ud_sweep_ctrl
   import ud_sweep_ctrl_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH-1:0]   lo_limit,
   input  logic [WIDTH-1:0]   hi_limit,
`ifdef SWEEP_DWELL_EN
   input  logic [DWELL_W-1:0] dwell_cycles,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               dir,
   output logic               cnt_en,
   output logic               busy,
   output logic               done,
   output logic               err,
   output state_t             state_dbg
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] lo_r, hi_r;
   logic             dir_r, err_r;
   logic             accept, reject, turn, step;

`ifdef SWEEP_DWELL_EN
   logic [DWELL_W-1:0] dwell_r, timer;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         lo_r  <= '0;
         hi_r  <= '0;
         dir_r <= DIR_UP;
         err_r <= 1'b0;
      end else begin
         state <= state_nx;
         err_r <= reject;
         if (accept) begin
            lo_r  <= lo_limit;
            hi_r  <= hi_limit;
            dir_r <= DIR_UP;
         end else if (turn) begin
            dir_r <= DIR_DN;
         end
      end
   end

`ifdef SWEEP_DWELL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_r <= '0;
         timer   <= '0;
      end else begin
         if (accept) dwell_r <= dwell_cycles;
         timer <= (state == ST_DWELL && state_nx == ST_DWELL) ? timer + 1'b1 : '0;
      end
   end
`endif

   // Abort overrides every transition and suppresses the counter step on the same edge.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      turn     = 1'b0;
      step     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start && !abort) begin
               if (lo_limit <= hi_limit) begin
                  accept   = 1'b1;
                  state_nx = ST_UP;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         ST_UP: begin
            if (count != hi_r) begin
               step = 1'b1;
`ifdef SWEEP_DWELL_EN
            end else if (dwell_r != '0) begin
               state_nx = ST_DWELL;
`endif
            end else begin
               state_nx = ST_DOWN;
               turn     = 1'b1;
            end
         end
         ST_DWELL: begin
`ifdef SWEEP_DWELL_EN
            if (timer == dwell_r - 1'b1) begin
               state_nx = ST_DOWN;
               turn     = 1'b1;
            end
`else
            state_nx = ST_IDLE;
`endif
         end
         ST_DOWN: begin
            if (count != lo_r) step = 1'b1;
            else               state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
      if (abort && state != ST_IDLE) begin
         state_nx = ST_IDLE;
         turn     = 1'b0;
         step     = 1'b0;
      end
   end

   ud_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (lo_limit),
      .en       (step),
      .up_down  (dir_r),
      .count    (count)
   );

   assign dir       = dir_r;
   assign cnt_en    = step;
   assign busy      = (state == ST_UP) || (state == ST_DWELL) || (state == ST_DOWN);
   assign done      = (state == ST_DONE);
   assign err       = err_r;
   assign state_dbg = state;

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// Bench for ud_sweep_ctrl: per-edge expected traces built from the sweep rules.
// Define SWEEP_DWELL_EN for both bench and RTL to cover the dwell variant.
module tb_ud_sweep_ctrl;
   import ud_sweep_ctrl_pkg::*;

   localparam int WIDTH   = 4;
   localparam int DWELL_W = 4;
   localparam int EW      = WIDTH + 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               abort = 1'b0;
   logic [WIDTH-1:0]   lo_limit = '0;
   logic [WIDTH-1:0]   hi_limit = '0;
`ifdef SWEEP_DWELL_EN
   logic [DWELL_W-1:0] dwell_cycles = '0;
`endif
   logic [WIDTH-1:0]   count;
   logic               dir, cnt_en, busy, done, err;
   state_t             state_dbg;

   int checks = 0;
   int errors = 0;
   int cur_count = 0;

   // {count, dir, cnt_en, busy, done} expected after each edge from the accept edge on
   logic [EW-1:0] exp_q[$];

   ud_sweep_ctrl #(.WIDTH(WIDTH), .DWELL_W(DWELL_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .lo_limit     (lo_limit),
      .hi_limit     (hi_limit),
`ifdef SWEEP_DWELL_EN
      .dwell_cycles (dwell_cycles),
`endif
      .count        (count),
      .dir          (dir),
      .cnt_en       (cnt_en),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_model(input int lo, input int hi, input int dw);
      exp_q.delete();
      for (int v = lo; v <= hi; v++)
         exp_q.push_back({WIDTH'(v), 1'b1, (v != hi), 1'b1, 1'b0});
      for (int d = 0; d < dw; d++)
         exp_q.push_back({WIDTH'(hi), 1'b1, 1'b0, 1'b1, 1'b0});
      for (int v = hi; v >= lo; v--)
         exp_q.push_back({WIDTH'(v), 1'b0, (v != lo), 1'b1, 1'b0});
      exp_q.push_back({WIDTH'(lo), 1'b0, 1'b0, 1'b0, 1'b1});
   endtask

   task automatic run_sweep(input int lo, input int hi, input int dw, input bit noise);
      logic [EW-1:0] exp;
      int k;
      build_model(lo, hi, dw);
      lo_limit = WIDTH'(lo);
      hi_limit = WIDTH'(hi);
`ifdef SWEEP_DWELL_EN
      dwell_cycles = DWELL_W'(dw);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         checks++;
         if ({count, dir, cnt_en, busy, done} !== exp) begin
            errors++;
            $display("FAIL sweep lo=%0d hi=%0d dw=%0d step %0d: got cnt=%0d dir=%b en=%b busy=%b done=%b, want cnt=%0d dir=%b en=%b busy=%b done=%b",
                     lo, hi, dw, k, count, dir, cnt_en, busy, done,
                     exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
         end
         checks++;
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL sweep_err lo=%0d hi=%0d step %0d: got err=%b, want 0", lo, hi, k, err);
         end
         if (exp_q.size() > 0) begin
            if (noise) begin
               start    = 1'($urandom_range(0, 1));
               lo_limit = WIDTH'($urandom_range(0, 15));
               hi_limit = WIDTH'($urandom_range(0, 15));
`ifdef SWEEP_DWELL_EN
               dwell_cycles = DWELL_W'($urandom_range(0, 15));
`endif
            end
            tick();
            k++;
         end
      end
      start = 1'b0;
      tick();
      checks++;
      if ({count, busy, done, cnt_en} !== {WIDTH'(lo), 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sweep_idle lo=%0d hi=%0d: got cnt=%0d busy=%b done=%b en=%b, want cnt=%0d busy=0 done=0 en=0",
                  lo, hi, count, busy, done, cnt_en, lo);
      end
      cur_count = lo;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({count, dir, cnt_en, busy, done, err} !== {WIDTH'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got cnt=%0d dir=%b en=%b busy=%b done=%b err=%b, want cnt=0 dir=1 en=0 busy=0 done=0 err=0",
                  count, dir, cnt_en, busy, done, err);
      end
      cur_count = 0;
   endtask

   task automatic test_err(input int lo, input int hi);
      lo_limit = WIDTH'(lo);
      hi_limit = WIDTH'(hi);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if ({err, busy, cnt_en, count} !== {1'b1, 1'b0, 1'b0, WIDTH'(cur_count)}) begin
         errors++;
         $display("FAIL err_pulse lo=%0d hi=%0d: got err=%b busy=%b en=%b cnt=%0d, want err=1 busy=0 en=0 cnt=%0d",
                  lo, hi, err, busy, cnt_en, count, cur_count);
      end
      tick();
      checks++;
      if ({err, busy, count} !== {1'b0, 1'b0, WIDTH'(cur_count)}) begin
         errors++;
         $display("FAIL err_clear: got err=%b busy=%b cnt=%0d, want err=0 busy=0 cnt=%0d",
                  err, busy, count, cur_count);
      end
   endtask

   task automatic test_abort();
      logic [EW-1:0] exp;
      build_model(2, 12, 0);
      lo_limit = 4'd2;
      hi_limit = 4'd12;
`ifdef SWEEP_DWELL_EN
      dwell_cycles = '0;
`endif
      start = 1'b1;
      tick();
      // start stays high through the sweep and must be ignored
      for (int k = 0; k <= 5; k++) begin
         exp = exp_q.pop_front();
         checks++;
         if ({count, dir, cnt_en, busy, done} !== exp) begin
            errors++;
            $display("FAIL abort_run step %0d: got cnt=%0d dir=%b en=%b busy=%b done=%b, want cnt=%0d dir=%b en=%b busy=%b done=%b",
                     k, count, dir, cnt_en, busy, done, exp[EW-1:4], exp[3], exp[2], exp[1], exp[0]);
         end
         if (k < 5) tick();
      end
      abort = 1'b1;
      start = 1'b0;
      tick();
      abort = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({count, dir, cnt_en, busy, done} !== {WIDTH'(7), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_hold cycle %0d: got cnt=%0d dir=%b en=%b busy=%b done=%b, want cnt=7 dir=1 en=0 busy=0 done=0",
                     k, count, dir, cnt_en, busy, done);
         end
         tick();
      end
      cur_count = 7;
   endtask

   task automatic test_fixed_sweeps();
      run_sweep(0, 3, 0, 1'b0);
      run_sweep(5, 5, 0, 1'b0);
      run_sweep(0, 15, 0, 1'b0);
      run_sweep(15, 15, 0, 1'b1);
`ifdef SWEEP_DWELL_EN
      run_sweep(0, 15, 3, 1'b0);
      run_sweep(4, 4, 2, 1'b0);
`endif
   endtask

   task automatic test_random();
      int lo, hi, dw;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            lo = $urandom_range(1, 15);
            hi = $urandom_range(0, lo - 1);
            test_err(lo, hi);
         end else begin
            lo = $urandom_range(0, 15);
            hi = $urandom_range(lo, 15);
`ifdef SWEEP_DWELL_EN
            dw = $urandom_range(0, 5);
`else
            dw = 0;
`endif
            run_sweep(lo, hi, dw, 1'b1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_sweeps();
      test_err(9, 4);
      test_abort();
      test_err(15, 0);
      test_random();
      run_sweep(0, 0, 0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
